// File: rtl/add_acc_pipe.sv
// Two-stage add / accumulate pipeline with valid-ready handshaking on both sides.
// Stage 1 registers the truncated operands; stage 2 computes the wrapped or clamped sum.
module add_acc_pipe #(
   parameter int DATAWIDTH = 8,
   parameter int AWIDTH    = 32,
   parameter int BWIDTH    = 16,
   parameter int SATURATE  = 0
) (
   input  logic                 Clk,
   input  logic                 Rst,
   input  logic [AWIDTH-1:0]    a,
   input  logic [BWIDTH-1:0]    b,
   input  logic                 in_valid,
   input  logic                 acc_en,
   input  logic                 clr,
   output logic                 in_ready,
   output logic [DATAWIDTH-1:0] c,
   output logic                 ovf,
   output logic                 out_valid,
   input  logic                 out_ready
);

   logic                 s1_vld_q, s1_acc_en_q, s1_clr_q;
   logic [DATAWIDTH-1:0] s1_a_q, s1_b_q;
   logic [DATAWIDTH-1:0] acc_q, c_q;
   logic                 ovf_q, out_valid_q;

   logic                 advance;
   logic [DATAWIDTH+1:0] base_d, raw_d;
   logic [DATAWIDTH-1:0] res_d;
   logic                 ovf_d;

   // Operand bits above DATAWIDTH are intentionally discarded.
   logic unused_hi_bits;
   assign unused_hi_bits = ^{a, b};

   always_comb begin
      advance = !out_valid_q || out_ready;
      base_d  = '0;
      if (s1_acc_en_q && !s1_clr_q)
         base_d = {2'b00, acc_q};
      // Plain mode is the same sum with a zero base; two guard bits cover both modes.
      raw_d = base_d + {2'b00, s1_a_q} + {2'b00, s1_b_q};
      ovf_d = |raw_d[DATAWIDTH+1:DATAWIDTH];
      res_d = raw_d[DATAWIDTH-1:0];
      if (ovf_d && (SATURATE != 0))
         res_d = '1;
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         s1_vld_q    <= 1'b0;
         s1_acc_en_q <= 1'b0;
         s1_clr_q    <= 1'b0;
         s1_a_q      <= '0;
         s1_b_q      <= '0;
         acc_q       <= '0;
         c_q         <= '0;
         ovf_q       <= 1'b0;
         out_valid_q <= 1'b0;
      end else if (advance) begin
         s1_vld_q    <= in_valid;
         s1_acc_en_q <= acc_en;
         s1_clr_q    <= clr;
         s1_a_q      <= a[DATAWIDTH-1:0];
         s1_b_q      <= b[DATAWIDTH-1:0];
         out_valid_q <= s1_vld_q;
         if (s1_vld_q) begin
            c_q   <= res_d;
            ovf_q <= ovf_d;
            if (s1_acc_en_q)
               acc_q <= res_d;
         end
      end
   end

   assign in_ready  = advance && !Rst;
   assign c         = c_q;
   assign ovf       = ovf_q;
   assign out_valid = out_valid_q;

endmodule
